// File: rtl/systolic_drain_if.sv
// Readout, drain-request and result-stream signals between the drain engine,
// the systolic array and the downstream consumer.
interface systolic_drain_if #(
  parameter int size  = 4,
  parameter int nbits = 16
);
  localparam int SW = $clog2(size);

  logic             start_val;
  logic             start_rdy;
  logic             start_col_major;
  logic [SW-1:0]    out_rsel;
  logic [SW-1:0]    out_csel;
  logic [nbits-1:0] b_s_in;
  logic [nbits-1:0] send_msg;
  logic             send_val;
  logic             send_rdy;
  logic             send_last;
  logic             busy;

  modport master (
    input  start_val, start_col_major, b_s_in, send_rdy,
    output start_rdy, out_rsel, out_csel, send_msg, send_val, send_last, busy
  );

  modport slave (
    output start_val, start_col_major, b_s_in, send_rdy,
    input  start_rdy, out_rsel, out_csel, send_msg, send_val, send_last, busy
  );
endinterface

// File: rtl/systolic_drain.sv
// Sweeps every PE address of the systolic array, samples each partial sum and
// streams it out over a val/rdy interface in row- or column-major order.
module systolic_drain #(
  parameter int size  = 4,
  parameter int nbits = 16
) (
  input logic              clk,
  input logic              rst,
  systolic_drain_if.master bus
);
  localparam int SW = $clog2(size);
  localparam logic [SW-1:0] MAX_IDX = SW'(size - 1);

  typedef enum logic [1:0] {IDLE, SEL, SEND} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    r_q, r_d;
  logic [SW-1:0]    c_q, c_d;
  logic             order_q, order_d;
  logic [nbits-1:0] msg_q, msg_d;
  logic             last_w;

  assign last_w = (r_q == MAX_IDX) && (c_q == MAX_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      order_q <= 1'b0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      order_q <= order_d;
      msg_q   <= msg_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    c_d           = c_q;
    order_d       = order_q;
    msg_d         = msg_q;
    bus.start_rdy = 1'b0;
    bus.busy      = 1'b1;
    bus.send_val  = 1'b0;
    bus.send_last = 1'b0;
    bus.send_msg  = msg_q;
    bus.out_rsel  = r_q;
    bus.out_csel  = c_q;

    unique case (state_q)
      IDLE: begin
        bus.start_rdy = 1'b1;
        bus.busy      = 1'b0;
        bus.out_rsel  = '0;
        bus.out_csel  = '0;
        if (bus.start_val) begin
          order_d = bus.start_col_major;
          r_d     = '0;
          c_d     = '0;
          state_d = SEL;
        end
      end
      SEL: begin
        msg_d   = bus.b_s_in;
        state_d = SEND;
      end
      SEND: begin
        bus.send_val  = 1'b1;
        bus.send_last = last_w;
        if (bus.send_rdy) begin
          if (last_w) begin
            r_d     = '0;
            c_d     = '0;
            state_d = IDLE;
          end else begin
            // Explicit compare keeps wrap correct for non-power-of-two sizes.
            if (!order_q) begin
              if (c_q == MAX_IDX) begin
                c_d = '0;
                r_d = r_q + SW'(1);
              end else begin
                c_d = c_q + SW'(1);
              end
            end else begin
              if (r_q == MAX_IDX) begin
                r_d = '0;
                c_d = c_q + SW'(1);
              end else begin
                r_d = r_q + SW'(1);
              end
            end
            state_d = SEL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain with a 0xRC array stub.
module tb_systolic_drain;
  localparam int SIZE  = 4;
  localparam int NBITS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] got_w[$];
  int          got_c[$];
  bit          got_l[$];
  int          t_start;

  systolic_drain_if #(.size(SIZE), .nbits(NBITS)) bus ();

  systolic_drain #(.size(SIZE), .nbits(NBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Array stub: result at (r,c) is 0xRC.
  always_comb bus.b_s_in = {8'h00, 2'b00, bus.out_rsel, 2'b00, bus.out_csel};

  function automatic logic [15:0] exp_word(input int k, input bit col_major);
    int r, c;
    if (col_major) begin c = k / SIZE; r = k % SIZE; end
    else           begin r = k / SIZE; c = k % SIZE; end
    return 16'((r << 4) | c);
  endfunction

  task automatic do_start(input bit cm);
    @(negedge clk);
    bus.start_val       = 1'b1;
    bus.start_col_major = cm;
    t_start             = cyc;
    checks++;
    if (bus.start_rdy !== 1'b1) begin
      errors++;
      $display("FAIL start_rdy_at_start got=%0b exp=1", bus.start_rdy);
    end
    @(negedge clk);
    bus.start_val       = 1'b0;
    bus.start_col_major = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready; pulse_k>=0 pulses start_val while word pulse_k is offered
  task automatic collect(input int mode, input int max_words, input int pulse_k);
    int budget;
    got_w.delete(); got_c.delete(); got_l.delete();
    budget = 400;
    while (budget > 0) begin
      budget--;
      bus.start_val       = (pulse_k >= 0) && bus.send_val && (got_w.size() == pulse_k);
      bus.start_col_major = bus.start_val;
      bus.send_rdy        = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.send_val && bus.send_rdy) begin
        got_w.push_back(bus.send_msg);
        got_c.push_back(cyc);
        got_l.push_back(bus.send_last);
        if (bus.send_last || got_w.size() == max_words) break;
      end
      @(negedge clk);
    end
    bus.start_val       = 1'b0;
    bus.start_col_major = 1'b0;
  endtask

  task automatic check_seq(input string name, input bit cm, input bit timing);
    checks++;
    if (got_w.size() != SIZE * SIZE) begin
      errors++;
      $display("FAIL %s_count got=%0d exp=%0d", name, got_w.size(), SIZE * SIZE);
    end
    for (int k = 0; k < got_w.size() && k < SIZE * SIZE; k++) begin
      checks++;
      if (got_w[k] !== exp_word(k, cm)) begin
        errors++;
        $display("FAIL %s_word%0d got=%h exp=%h", name, k, got_w[k], exp_word(k, cm));
      end
      checks++;
      if (got_l[k] !== (k == SIZE * SIZE - 1)) begin
        errors++;
        $display("FAIL %s_last%0d got=%0b exp=%0b", name, k, got_l[k], k == SIZE * SIZE - 1);
      end
      if (timing) begin
        checks++;
        if (got_c[k] != t_start + 2 + 2 * k) begin
          errors++;
          $display("FAIL %s_cycle%0d got=%0d exp=%0d", name, k, got_c[k] - t_start, 2 + 2 * k);
        end
      end
    end
    $display("%s: %0d words collected", name, got_w.size());
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.send_val, bus.send_last, bus.busy, bus.start_rdy} !== 4'b0001 ||
        bus.out_rsel !== 2'd0 || bus.out_csel !== 2'd0 || bus.send_msg !== 16'h0) begin
      errors++;
      $display("FAIL reset val=%0b last=%0b busy=%0b rdy=%0b rsel=%0d csel=%0d msg=%h exp 0/0/0/1/0/0/0000",
               bus.send_val, bus.send_last, bus.busy, bus.start_rdy,
               bus.out_rsel, bus.out_csel, bus.send_msg);
    end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_row_major;
    do_start(1'b0);
    collect(0, 99, -1);
    check_seq("row", 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.start_rdy !== 1'b1 || bus.busy !== 1'b0 || cyc != t_start + 2 * SIZE * SIZE + 1) begin
      errors++;
      $display("FAIL row_idle_return rdy=%0b busy=%0b cyc=%0d exp rdy=1 busy=0 cyc=%0d",
               bus.start_rdy, bus.busy, cyc - t_start, 2 * SIZE * SIZE + 1);
    end
  endtask

  task automatic test_col_major;
    do_start(1'b1);
    collect(0, 99, -1);
    check_seq("col", 1'b1, 1'b1);
  endtask

  task automatic test_backpressure;
    int budget, rel;
    do_start(1'b0);
    budget = 40;
    bus.send_rdy = 1'b1;
    while (budget > 0 && !(bus.send_val && bus.send_msg == 16'h0003)) begin
      @(negedge clk);
      budget--;
    end
    bus.send_rdy = 1'b0;
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL bp_reach_word3 got=timeout exp=0003");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.send_val !== 1'b1 || bus.send_msg !== 16'h0003 || bus.send_last !== 1'b0 ||
          bus.out_rsel !== 2'd0 || bus.out_csel !== 2'd3) begin
        errors++;
        $display("FAIL bp_hold%0d val=%0b msg=%h last=%0b r=%0d c=%0d exp 1/0003/0/0/3",
                 i, bus.send_val, bus.send_msg, bus.send_last, bus.out_rsel, bus.out_csel);
      end
    end
    bus.send_rdy = 1'b1;
    rel = cyc;
    @(negedge clk);
    bus.send_rdy = 1'b0;
    budget = 10;
    while (budget > 0 && !bus.send_val) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (bus.send_msg !== 16'h0010 || cyc != rel + 2) begin
      errors++;
      $display("FAIL bp_after_release msg=%h dt=%0d exp msg=0010 dt=2", bus.send_msg, cyc - rel);
    end
    collect(0, 99, -1);
    checks++;
    if (got_w.size() != 12 || got_w[0] !== 16'h0010 || got_w[got_w.size()-1] !== 16'h0033) begin
      errors++;
      $display("FAIL bp_tail count=%0d exp=12", got_w.size());
    end
    $display("backpressure: held 5 cycles, tail %0d words", got_w.size());
  endtask

  task automatic test_random_rdy;
    do_start(1'b0);
    collect(1, 99, -1);
    check_seq("rand", 1'b0, 1'b0);
  endtask

  task automatic test_start_busy;
    do_start(1'b0);
    collect(0, 99, 5);
    check_seq("busy_start", 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.send_val !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_queued busy=%0b val=%0b exp 0/0", bus.busy, bus.send_val);
    end
  endtask

  task automatic test_reset_mid;
    do_start(1'b0);
    collect(0, 5, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.send_val !== 1'b0 || bus.busy !== 1'b0 || bus.start_rdy !== 1'b1 ||
        bus.out_rsel !== 2'd0 || bus.out_csel !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset val=%0b busy=%0b rdy=%0b r=%0d c=%0d exp 0/0/1/0/0",
               bus.send_val, bus.busy, bus.start_rdy, bus.out_rsel, bus.out_csel);
    end
    do_start(1'b0);
    collect(0, 99, -1);
    check_seq("after_reset", 1'b0, 1'b1);
  endtask

  initial begin
    bus.start_val       = 1'b0;
    bus.start_col_major = 1'b0;
    bus.send_rdy        = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_row_major();
    test_col_major();
    test_backpressure();
    test_random_rdy();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Result-readout engine for the systolic array. It is the consumer side of the array's out_rsel/out_csel/b_s_out readout port.
- On a drain request it sweeps every PE address (size×size), samples the selected partial-sum result, and streams it out over a val/rdy send interface.
- It sits between the systolic array and the downstream serializer or host bus, replacing ad-hoc testbench/host selection of results.

Parameters:
- size, 4, array dimension; must be ≥2. Select width is $clog2(size).
- nbits, 16, result word width (matches array nbits).

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous, active-high.
- start_val  input  1  drain request valid.
- start_rdy  output  1  drain request ready. High only in IDLE.
- start_col_major  input  1  order select, sampled on start handshake: 0 = row-major, 1 = column-major.
- out_rsel  output  $clog2(size)  row select driven to the array.
- out_csel  output  $clog2(size)  column select driven to the array.
- b_s_in  input  nbits  selected result from the array. Combinational function of out_rsel/out_csel.
- send_msg  output  nbits  result word.
- send_val  output  1  result valid.
- send_rdy  input  1  downstream ready.
- send_last  output  1  high with send_val on the final (size*size-th) word.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, SEL, SEND. Registered state, row counter r, column counter c, order bit, output register msg.
- Reset (takes effect at the clock edge where rst=1):
  - state=IDLE, r=c=0, order=0, send_msg=0.
  - send_val=0, send_last=0, busy=0, start_rdy=1.
  - out_rsel=out_csel=0.
- IDLE:
  - start_rdy=1; selects held at 0.
  - On start_val&start_rdy: latch start_col_major into order, clear r and c, go to SEL.
- SEL (one cycle):
  - out_rsel=r, out_csel=c.
  - At the clock edge, b_s_in is captured into msg; go to SEND.
- SEND:
  - send_val=1, send_msg=msg. Selects stay at r/c.
  - send_last=1 iff both counters are at size-1.
  - send_msg and send_last must remain stable while send_rdy=0, for an unbounded time.
- Handshake in SEND (send_val&send_rdy):
  - If last: go to IDLE, clear r and c.
  - Otherwise advance the address and go to SEL.
  - Row-major advance: c increments; when c wraps from size-1 to 0, r increments.
  - Column-major advance: r increments; when r wraps from size-1 to 0, c increments.
- Throughput: 2 cycles per word with no backpressure.
  - Start handshake at cycle t → first send_val at t+2.
  - Word k is offered at t+2+2k; the last word is offered at t+2·size².
  - Back in IDLE (start_rdy=1) at t+2·size²+1 if send_rdy stays high.
- b_s_in is sampled only in SEL; its value in other states is ignored.
- start_val while busy: ignored (start_rdy=0), with no queuing. start_col_major is ignored outside the start handshake.
- send_rdy high outside SEND: no effect.
- Reset mid-drain: abandon immediately. Next cycle send_val=0, state IDLE, counters 0; partially sent matrix is not resumed.
- Counters are exactly $clog2(size) bits.
  - For non-power-of-two size, wrap is an explicit compare against size-1, never natural overflow.
  - Select values ≥size never appear on out_rsel/out_csel.

Test Plan:
- Reset: hold rst 2 cycles mid-idle → send_val=0, send_last=0, busy=0, start_rdy=1, out_rsel=out_csel=0, send_msg=0.
- Row-major full drain:
  - Setup: size=4; array stub returns b_s_in = {r,c} as 0xRC; send_rdy=1; start at cycle t.
  - Required: words 0x00,0x01,0x02,0x03,0x10…0x33 at cycles t+2, t+4 … t+32.
  - send_last only on 0x33; start_rdy=1 again at t+33.
- Column-major drain: start_col_major=1 → sequence 0x00,0x10,0x20,0x30,0x01…0x33; send_last only on 0x33.
- Backpressure:
  - Stimulus: drop send_rdy for 5 cycles while word 3 (0x03) is offered.
  - Required: send_val stays 1, send_msg=0x03 stable, selects hold (r=0,c=3); then 0x10 follows 2 cycles after release.
  - Randomized send_rdy over the full drain still yields all 16 words in order.
- Start while busy: pulse start_val with start_col_major=1 during word 5 → ignored; drain continues row-major and produces exactly 16 words.
- Reset mid-drain:
  - Stimulus: assert rst after 5 words accepted.
  - Required: next cycle send_val=0, busy=0.
  - A new start then produces 0x00 as the first word and a complete 16-word sequence.
